// File: rtl/rr_grant_arbiter_4_pkg.sv
// Shared types and constants for the 4-way round-robin grant arbiter.
// Optional hold timeout is enabled by defining ARB_TIMEOUT_EN.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Returns the first set request searching upward from last+1, wrapping.
  // A descending loop lets the nearest candidate overwrite farther ones.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] idx;
    rr_pick = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last + ID_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_4_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// The timeout signal exists only when ARB_TIMEOUT_EN is defined.
interface rr_grant_arbiter_4_if;
  import arb_pkg::*;

  // grant_valid is high exactly while grant is non-zero; a requester owns
  // the resource for every cycle its grant bit is set and releases it by
  // dropping its req bit (no separate ready: req itself acts as the hold).
  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_valid;
  state_e             state;
`ifdef ARB_TIMEOUT_EN
  logic               timeout;
`endif

  modport master (
    output en, req,
    input  grant, grant_id, grant_valid, state
`ifdef ARB_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  en, req,
    output grant, grant_id, grant_valid, state
`ifdef ARB_TIMEOUT_EN
    , output timeout
`endif
  );

endinterface

// File: rtl/rr_grant_arbiter_4_decoder_2to4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module decoder_2to4 (
  input  logic [1:0] din,
  input  logic       en,
  output logic [3:0] dout
);

  always_comb begin
    dout = 4'b0000;
    if (en) dout[din] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_arbiter_4.sv
// Round-robin arbiter for 4 requesters with a one-cycle IDLE gap between grants.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX consecutive grant cycles.
module rr_grant_arbiter_4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_grant_arbiter_4_if.slave bus
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range
    $error("HOLD_MAX must be in 2..255");
  end

  state_e          state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] last_id_q, last_id_d;
`ifdef ARB_TIMEOUT_EN
  logic [7:0]      cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_id_q  <= '1;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Releasing always lands in IDLE, so a new winner is only ever chosen
  // from IDLE; this is what guarantees the grant=0 gap between owners.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.en && (|bus.req)) begin
          state_d    = GRANT;
          grant_id_d = rr_pick(bus.req, last_id_q);
          last_id_d  = grant_id_d;
`ifdef ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      GRANT: begin
        if (!bus.en || !bus.req[grant_id_q]) begin
          state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == 8'(HOLD_MAX - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant_valid = (state_q == GRANT);
  assign bus.grant_id    = grant_id_q;
  assign bus.state       = state_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout     = timeout_q;
`endif

  decoder_2to4 u_dec (
    .din  (grant_id_q),
    .en   (bus.grant_valid),
    .dout (bus.grant)
  );

endmodule

// File: tb/tb_rr_grant_arbiter_4.sv
// Directed-vector bench for rr_grant_arbiter_4; define ARB_TIMEOUT_EN to
// also exercise the forced-release path.
module tb_rr_grant_arbiter_4;
  import arb_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  rr_grant_arbiter_4_if ifc ();

  rr_grant_arbiter_4 #(.HOLD_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] exp);
    chk({tag, ".grant"}, 8'(ifc.grant), 8'(exp));
    chk({tag, ".valid"}, 8'(ifc.grant_valid), 8'(exp != 4'b0000));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    ifc.en      = 1'b0;
    ifc.req     = 4'b0000;

    // Reset state
    do_reset();
    chk_grant("reset", 4'b0000);
    chk("reset.id", 8'(ifc.grant_id), 8'd0);
    chk("reset.state", 8'(ifc.state), 8'(IDLE));

    // Single requester grant/release with one-cycle latency
    ifc.en  = 1'b1;
    ifc.req = 4'b0001;
    tick();
    chk_grant("single.on", 4'b0001);
    chk("single.id", 8'(ifc.grant_id), 8'd0);
    chk("single.state", 8'(ifc.state), 8'(GRANT));
    ifc.req = 4'b0000;
    tick();
    chk_grant("single.off", 4'b0000);

    // Full rotation, each winner holds two cycles then drops
    do_reset();
    ifc.en  = 1'b1;
    ifc.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      tick();
      chk_grant("rot.c1", exp_g);
      tick();
      chk_grant("rot.c2", exp_g);
      ifc.req = 4'b1111 & ~exp_g;
      tick();
      chk_grant("rot.gap", 4'b0000);
      ifc.req = 4'b1111;
    end
    ifc.req = 4'b0000;
    tick();

    // Reach last_id=2, then 1011 -> 3, then wrap 0011 -> 0
    ifc.req = 4'b0100;
    tick();
    chk_grant("to2", 4'b0100);
    ifc.req = 4'b1011;
    tick();
    chk_grant("to2.rel", 4'b0000);
    tick();
    chk_grant("last2.1011", 4'b1000);
    chk("last2.id", 8'(ifc.grant_id), 8'd3);
    ifc.req = 4'b0011;
    tick();
    chk_grant("wrap.rel", 4'b0000);
    tick();
    chk_grant("wrap.0011", 4'b0001);

    // Enable drop while granted to requester 1
    ifc.req = 4'b0010;
    tick();
    chk_grant("en.rel0", 4'b0000);
    tick();
    chk_grant("en.g1", 4'b0010);
    ifc.en = 1'b0;
    tick();
    chk_grant("en.off", 4'b0000);
    ifc.en = 1'b1;
    tick();
    chk_grant("en.again", 4'b0010);

    // en=0 blocks new grants from IDLE
    ifc.req = 4'b0000;
    tick();
    ifc.en  = 1'b0;
    ifc.req = 4'b1111;
    tick();
    chk_grant("blk.1", 4'b0000);
    tick();
    chk_grant("blk.2", 4'b0000);
    ifc.en = 1'b1;
    tick();
    chk_grant("blk.resume", 4'b0100);

    // Release and new requests in same cycle: release wins
    ifc.req = 4'b1011;
    tick();
    chk_grant("sim.rel", 4'b0000);
    tick();
    chk_grant("sim.next", 4'b1000);

    // Asynchronous reset mid-grant
    ifc.req = 4'b0010;
    tick();
    tick();
    chk_grant("ar.g1", 4'b0010);
    rst_n = 1'b0;
    #1;
    chk_grant("ar.async", 4'b0000);
    chk("ar.id", 8'(ifc.grant_id), 8'd0);
    tick();
    rst_n   = 1'b1;
    ifc.req = 4'b0011;
    tick();
    chk_grant("ar.first", 4'b0001);

`ifdef ARB_TIMEOUT_EN
    // Forced release after HOLD_MAX cycles
    do_reset();
    ifc.en  = 1'b1;
    ifc.req = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_grant("to.hold", 4'b0100);
      chk("to.quiet", 8'(ifc.timeout), 8'd0);
    end
    tick();
    chk_grant("to.rel", 4'b0000);
    chk("to.pulse", 8'(ifc.timeout), 8'd1);
    tick();
    chk_grant("to.regrant", 4'b0100);
    chk("to.pulse_end", 8'(ifc.timeout), 8'd0);
`else
    // Without the timeout a held request keeps its grant indefinitely
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_grant("hold.long", 4'b0001);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
